// File: rtl/crc8_frame_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_frame_engine_if
//  Description : Word-stream bundle for the CRC-8 frame engine. It carries the
//                inbound data word with its framing flags and the outbound
//                registered word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc8_frame_engine_if #(
    parameter int WORDWIDTH = 40
) ();
    logic [WORDWIDTH-1:0] din;
    logic                 din_valid;
    logic                 sof;
    logic                 eof;
    logic [WORDWIDTH-1:0] dout;
    logic                 dout_valid;

    // Frame builder side: drives words, receives the processed stream
    modport master (
        output din, din_valid, sof, eof,
        input  dout, dout_valid
    );

    // Engine side
    modport slave (
        input  din, din_valid, sof, eof,
        output dout, dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/crc8_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_frame_engine
//  Description : CRC-8 accumulator across multi-word frames. Check mode
//                verifies the CRC byte in the eof word. Generate mode
//                replaces that byte with the computed CRC.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_frame_engine #(
    parameter int         WORDWIDTH   = 40,
    parameter logic [7:0] POLY        = 8'h2F,
    parameter logic [7:0] INIT        = 8'h00,
    parameter int         ERRCNTWIDTH = 16,
    parameter int         FRMCNTWIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   dis,
    input  wire logic                   mode,
    input  wire logic                   err_clr,
    crc8_frame_engine_if.slave          bus,
    output logic [7:0]                  crc_out,
    output logic                        frame_done,
    output logic                        crc_err,
    output logic                        abort,
    output logic                        orphan,
    output logic [ERRCNTWIDTH-1:0]      err_cnt,
    output logic [FRMCNTWIDTH-1:0]      frm_cnt
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_IN_FRAME = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [7:0]             r_crc;
    logic                   r_mode;
    logic [WORDWIDTH-1:0]   r_dout;
    logic                   r_dout_valid;
    logic [7:0]             r_crc_out;
    logic                   r_frame_done;
    logic                   r_crc_err;
    logic                   r_abort;
    logic                   r_orphan;
    logic [ERRCNTWIDTH-1:0] r_err_cnt;
    logic [FRMCNTWIDTH-1:0] r_frm_cnt;

    logic                   w_accept;
    logic                   w_fwd;
    logic                   w_orphan;
    logic                   w_abort;
    logic                   w_done;
    logic                   w_mode;
    logic                   w_crc_err;
    logic [7:0]             w_crc_data;
    logic [7:0]             w_crc_full;

    // One MSB-first LFSR step; x^8 term is implicit in the shift-out
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? POLY : 8'h00);
    endfunction

    // CRC over the data field, then continued through the CRC byte; a correct
    // trailing byte drives the continued value (the residue) to zero
    always_comb begin
        w_crc_data = bus.sof ? INIT : r_crc;
        for (int i = WORDWIDTH-1; i >= 8; i--) begin
            w_crc_data = crc_step(w_crc_data, bus.din[i]);
        end
        w_crc_full = w_crc_data;
        for (int i = 7; i >= 0; i--) begin
            w_crc_full = crc_step(w_crc_full, bus.din[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: any forwarded word opens a frame unless it also closes it
    always_comb begin
        w_state_next = r_state;
        if (w_fwd) begin
            w_state_next = bus.eof ? S_IDLE : S_IN_FRAME;
        end
    end

    // FSM output decode: per-word event strobes
    always_comb begin
        w_accept  = bus.din_valid & ~dis;
        w_orphan  = w_accept & ~bus.sof & (r_state == S_IDLE);
        w_fwd     = w_accept & ~w_orphan;
        w_abort   = w_accept & bus.sof & (r_state == S_IN_FRAME);
        w_done    = w_fwd & bus.eof;
        // A sof word uses the live mode; later words use the one latched at sof
        w_mode    = bus.sof ? mode : r_mode;
        w_crc_err = w_done & ~w_mode & (w_crc_full != 8'h00);
    end

    // Datapath, pulse and counter registers; dis freezes all of them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc        <= INIT;
            r_mode       <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_crc_out    <= 8'h00;
            r_frame_done <= 1'b0;
            r_crc_err    <= 1'b0;
            r_abort      <= 1'b0;
            r_orphan     <= 1'b0;
            r_err_cnt    <= '0;
            r_frm_cnt    <= '0;
        end else if (!dis) begin
            r_dout_valid <= w_fwd;
            r_frame_done <= w_done;
            r_crc_err    <= w_crc_err;
            r_abort      <= w_abort;
            r_orphan     <= w_orphan;
            if (w_fwd) begin
                if (w_done && w_mode) begin
                    r_dout <= {bus.din[WORDWIDTH-1:8], w_crc_data};
                end else begin
                    r_dout <= bus.din;
                end
                if (bus.sof) begin
                    r_mode <= mode;
                end
                r_crc <= bus.eof ? INIT : w_crc_full;
            end
            if (w_done) begin
                r_crc_out <= w_crc_data;
            end
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if ((w_crc_err || w_abort) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_done && !w_crc_err) begin
                r_frm_cnt <= r_frm_cnt + 1'b1;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign crc_out        = r_crc_out;
    assign frame_done     = r_frame_done;
    assign crc_err        = r_crc_err;
    assign abort          = r_abort;
    assign orphan         = r_orphan;
    assign err_cnt        = r_err_cnt;
    assign frm_cnt        = r_frm_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc8_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc8_frame_engine
//  Description : Self-checking bench for crc8_frame_engine. A reference model
//                recomputes each frame's CRC from scratch over the whole
//                collected bit stream and queues the expected outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_frame_engine;

    localparam int         W    = 40;
    localparam logic [7:0] POLY = 8'h2F;
    localparam logic [7:0] INIT = 8'h00;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         dv;
        logic         fd;
        logic [7:0]   co;
        logic         ce;
        logic         ab;
        logic         orp;
        logic [1:0]   ec;
        logic [15:0]  fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dis;
    logic        mode;
    logic        err_clr;
    logic [7:0]  crc_out;
    logic        frame_done;
    logic        crc_err;
    logic        abort;
    logic        orphan;
    logic [1:0]  err_cnt;
    logic [15:0] frm_cnt;

    crc8_frame_engine_if #(.WORDWIDTH(W)) bus ();

    crc8_frame_engine #(
        .WORDWIDTH   (W),
        .POLY        (POLY),
        .INIT        (INIT),
        .ERRCNTWIDTH (2),
        .FRMCNTWIDTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dis        (dis),
        .mode       (mode),
        .err_clr    (err_clr),
        .bus        (bus.slave),
        .crc_out    (crc_out),
        .frame_done (frame_done),
        .crc_err    (crc_err),
        .abort      (abort),
        .orphan     (orphan),
        .err_cnt    (err_cnt),
        .frm_cnt    (frm_cnt)
    );

    always #5 clk = ~clk;

    obs_t sb[$];
    obs_t m_prev;
    logic m_in;
    logic m_mode;
    bit   m_bits[$];
    int   checks = 0;
    int   errors = 0;

    // CRC from INIT over the first n bits collected in the current frame
    function automatic logic [7:0] ref_crc(input int n);
        logic [7:0] c;
        logic       fb;
        c = INIT;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ m_bits[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic obs_t sample();
        return {bus.dout, bus.dout_valid, frame_done, crc_out, crc_err,
                abort, orphan, err_cnt, frm_cnt};
    endfunction

    // Reference behaviour of one cycle; pushes the expected registered outputs
    task automatic model_step(input logic [W-1:0] d, input logic s, input logic e,
                              input logic md, input logic v, input logic dc,
                              input logic clr);
        obs_t       x;
        logic [7:0] cd;
        logic [7:0] cf;
        x = m_prev;
        if (!dc) begin
            x.dv = 1'b0; x.fd = 1'b0; x.ce = 1'b0; x.ab = 1'b0; x.orp = 1'b0;
            if (v) begin
                if (!m_in && !s) begin
                    x.orp = 1'b1;
                end else begin
                    x.ab = s && m_in;
                    if (s) begin
                        m_bits.delete();
                        m_mode = md;
                    end
                    for (int i = W-1; i >= 0; i--) m_bits.push_back(d[i]);
                    x.dv   = 1'b1;
                    x.dout = d;
                    if (e) begin
                        cd   = ref_crc(m_bits.size() - 8);
                        cf   = ref_crc(m_bits.size());
                        x.fd = 1'b1;
                        x.co = cd;
                        if (m_mode) x.dout[7:0] = cd;
                        else        x.ce = (cf != 8'h00);
                        if (!x.ce) x.fc = x.fc + 16'd1;
                        m_in = 1'b0;
                    end else begin
                        m_in = 1'b1;
                    end
                end
            end
            if (clr) x.ec = 2'd0;
            else if ((x.ce || x.ab) && x.ec != 2'd3) x.ec = x.ec + 2'd1;
        end
        m_prev = x;
        sb.push_back(x);
    endtask

    task automatic send(input logic [W-1:0] d, input logic s, input logic e,
                        input logic md, input logic v, input logic dc,
                        input logic clr);
        bus.din = d; bus.sof = s; bus.eof = e; bus.din_valid = v;
        mode = md; dis = dc; err_clr = clr;
        model_step(d, s, e, md, v, dc, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_in   = 1'b0;
        m_mode = 1'b0;
        m_bits.delete();
        sb.delete();
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1; dis = 1'b0; mode = 1'b0; err_clr = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        o = sample();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", o, obs_t'(0));
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_word();
        obs_t e, o;
        send('0, 1, 1, 0, 1, 0, 0);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL zero_word: got %h expected %h", o, e); end
        checks++;
        if (crc_out !== 8'h00 || frm_cnt !== 16'd1 || crc_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_word_const: got crc=%h frm=%0d err=%b expected crc=00 frm=1 err=0",
                     crc_out, frm_cnt, crc_err);
        end
    endtask

    task automatic test_generate();
        obs_t e, o;
        send(40'h00_0000_0100, 1, 1, 1, 1, 0, 0);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL generate: got %h expected %h", o, e); end
        checks++;
        if (crc_out !== 8'h2F || bus.dout !== 40'h00_0000_012F || crc_err !== 1'b0) begin
            errors++;
            $display("FAIL generate_const: got crc=%h dout=%h err=%b expected crc=2f dout=000000012f err=0",
                     crc_out, bus.dout, crc_err);
        end
    endtask

    task automatic test_check();
        obs_t       e, o;
        logic [W-1:0] words [2];
        words[0] = 40'h00_0000_012F;
        words[1] = 40'h00_0000_012F ^ (40'h1 << 20);
        for (int i = 0; i < 2; i++) begin
            send(words[i], 1, 1, 0, 1, 0, 0);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL check word %0d: got %h expected %h", i, o, e); end
            checks++;
            if (crc_err !== logic'(i == 1)) begin
                errors++;
                $display("FAIL check_err word %0d: got %b expected %b", i, crc_err, i == 1);
            end
        end
        checks++;
        if (err_cnt !== 2'd1 || frm_cnt !== 16'd3) begin
            errors++;
            $display("FAIL check_counts: got err=%0d frm=%0d expected err=1 frm=3", err_cnt, frm_cnt);
        end
    endtask

    task automatic test_multiword();
        obs_t         e, o;
        logic [W-1:0] w [4];
        logic [W-1:0] g [4];
        for (int i = 0; i < 4; i++) w[i] = {$urandom(), 8'($urandom())};
        for (int i = 0; i < 4; i++) begin
            send(w[i], i == 0, i == 3, 1, 1, 0, 0);
            e = sb.pop_front(); o = sample(); g[i] = e.dout; checks++;
            if (o !== e) begin errors++; $display("FAIL multi_gen word %0d: got %h expected %h", i, o, e); end
        end
        for (int i = 0; i < 4; i++) begin
            send(g[i], i == 0, i == 3, 0, 1, 0, 0);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL multi_chk word %0d: got %h expected %h", i, o, e); end
        end
        checks++;
        if (crc_err !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL multi_chk_err: got err=%b done=%b expected err=0 done=1", crc_err, frame_done);
        end
    endtask

    task automatic test_abort_orphan();
        obs_t e, o;
        logic s [6] = '{1, 0, 1, 0, 0, 0};
        logic f [6] = '{0, 0, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            send({$urandom(), 8'($urandom())}, s[i], f[i], 1, 1, 0, 0);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL abort_orphan step %0d: got %h expected %h", i, o, e); end
            if (i == 2) begin
                checks++;
                if (abort !== 1'b1 || err_cnt !== 2'd2) begin
                    errors++;
                    $display("FAIL abort_pulse: got abort=%b err=%0d expected abort=1 err=2", abort, err_cnt);
                end
            end
            if (i >= 4) begin
                checks++;
                if (orphan !== 1'b1 || bus.dout_valid !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL orphan step %0d: got orphan=%b dv=%b done=%b expected 1 0 0",
                             i, orphan, bus.dout_valid, frame_done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 6; i++) begin
            send({$urandom(), 8'($urandom())}, (i % 2) == 0, (i % 2) == 1, 1, 1, 0, 0);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL back_to_back word %0d: got %h expected %h", i, o, e); end
        end
    endtask

    task automatic test_dis();
        obs_t e, o;
        logic v  [3] = '{0, 1, 1};
        logic dc [3] = '{0, 1, 1};
        logic cl [3] = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            send({$urandom(), 8'($urandom())}, 1, 1, 1, v[i], dc[i], cl[i]);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL dis step %0d: got %h expected %h", i, o, e); end
        end
        dis = 1'b0;
    endtask

    task automatic test_err_sat();
        obs_t e, o;
        send('0, 0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL err_clear: got %h expected %h", o, e); end
        for (int i = 0; i < 5; i++) begin
            send(40'h00_0000_0101, 1, 1, 0, 1, 0, 0);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL err_sat frame %0d: got %h expected %h", i, o, e); end
        end
        checks++;
        if (err_cnt !== 2'd3) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected 3", err_cnt);
        end
        send(40'h00_0000_0101, 1, 1, 0, 1, 0, 1);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL err_clr_priority: got %h expected %h", o, e); end
        checks++;
        if (err_cnt !== 2'd0 || crc_err !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_const: got err_cnt=%0d crc_err=%b expected 0 1", err_cnt, crc_err);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        send({$urandom(), 8'($urandom())}, 1, 0, 1, 1, 0, 0);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid_first: got %h expected %h", o, e); end
        bus.din = {$urandom(), 8'($urandom())}; bus.sof = 1'b0; bus.eof = 1'b1;
        #2 reset = 1'b1;
        #1;
        o = sample(); checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_async: got %h expected %h", o, obs_t'(0)); end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        send('0, 1, 1, 0, 1, 0, 0);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid_restart: got %h expected %h", o, e); end
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_generate();
        test_check();
        test_multiword();
        test_abort_orphan();
        test_back_to_back();
        test_dis();
        test_err_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
